// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter.
// Sequencer state encoding and default byte width.
package uart_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Producer and transmitter handshake bundle for uart_tx_arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEF
) ();

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         tx_data;
    logic                      byte_ready;
    logic                      t_byte;
    logic                      tx_done;
    logic                      busy;
    logic [ID_W-1:0]           grant_id;

    modport master (
        output req_valid, req_data, req_lock, tx_done,
        input  req_ready, tx_data, byte_ready, t_byte, busy, grant_id
    );

    modport slave (
        input  req_valid, req_data, req_lock, tx_done,
        output req_ready, tx_data, byte_ready, t_byte, busy, grant_id
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin select: first valid at or above ptr,
// wrapping around. Shared by the arbiters in this design.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic               found,
    output logic [ID_W-1:0]    winner
);

    logic [ID_W-1:0] idx;

    // Walk from the farthest candidate back to ptr so the nearest wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ producers.
// Define UART_ARB_LOCK_EN to let a requester hold the grant across bytes.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEF
) (
    input logic             clk,
    input logic             rst,
    uart_tx_arbiter_if.slave bus
);

    localparam int ID_W = $clog2(NUM_REQ);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_q;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   ptr_inc;
    logic [ID_W-1:0]   ptr_next;
    logic [DATA_W-1:0] tx_data_q;
    logic              found;
    logic              accept;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .valid  (bus.req_valid),
        .ptr    (rr_ptr),
        .found  (found),
        .winner (winner)
    );

    // No byte is taken while reset is held, so nothing is lost.
    assign accept = (state_q == IDLE) && found && !rst;

    assign ptr_inc = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

`ifdef UART_ARB_LOCK_EN
    logic lock_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q <= 1'b0;
        end else if (accept) begin
            lock_q <= bus.req_lock[winner];
        end
    end

    assign ptr_next = lock_q ? grant_q : ptr_inc;
`else
    logic unused_lock;

    assign unused_lock = ^bus.req_lock;
    assign ptr_next    = ptr_inc;
`endif

    always_comb begin
        state_d        = state_q;
        bus.req_ready  = '0;
        bus.byte_ready = 1'b0;
        bus.t_byte     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    bus.req_ready[winner] = 1'b1;
                    state_d               = LOAD;
                end
            end
            LOAD: begin
                bus.byte_ready = !rst;
                state_d        = START;
            end
            START: begin
                bus.t_byte = !rst;
                state_d    = WAIT;
            end
            WAIT: begin
                if (bus.tx_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr    <= '0;
            grant_q   <= '0;
            tx_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                grant_q   <= winner;
                tx_data_q <= bus.req_data[winner*DATA_W +: DATA_W];
            end
            if (state_q == WAIT && bus.tx_done) begin
                rr_ptr <= ptr_next;
            end
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.tx_data  = tx_data_q;
    assign bus.grant_id = grant_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter datapath between NUM_REQ byte producers. It accepts one byte at a time from the winning requester, drives the transmitter's load and start strobes in the order the transmitter controller expects, and waits for frame completion before granting again. It sits between the producer blocks and the UART transmitter top level.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- DATA_W, 8: byte width forwarded to the transmitter.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a byte pending.
- req_data  in  NUM_REQ*DATA_W  byte of requester i in bits [i*DATA_W +: DATA_W].
- req_lock  in  NUM_REQ  requester i asks to keep the grant for its next byte (only with UART_ARB_LOCK_EN).
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse; byte taken when req_valid[i] && req_ready[i].
- tx_data  out  DATA_W  byte presented to the transmitter shift register.
- byte_ready  out  1  one-cycle load strobe to the transmitter.
- t_byte  out  1  one-cycle start strobe to the transmitter.
- tx_done  in  1  one-cycle pulse from the transmitter when the stop bit ends.
- busy  out  1  high in every state except IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the current/last granted requester.

## Operation
- States: IDLE, LOAD, START, WAIT (2-bit encoding).
- IDLE: if any req_valid, select winner by searching from rr_ptr upward with wrap-around; first valid wins. Same cycle: req_ready[winner]=1, capture req_data slice into tx_data, grant_id<=winner, go LOAD. No valid: stay IDLE.
- LOAD: byte_ready=1 for exactly one cycle; go START.
- START: t_byte=1 for exactly one cycle; go WAIT.
- WAIT: hold tx_data and grant_id; on tx_done go IDLE and set rr_ptr <= (grant_id+1) mod NUM_REQ.
- tx_done outside WAIT is ignored.
- req_valid dropping after acceptance has no effect; the byte is already captured.
- Requester must hold req_data stable while req_valid is high and not yet accepted.

## Timing
- Reset: state IDLE, rr_ptr 0, req_ready 0, tx_data 0, byte_ready 0, t_byte 0, busy 0, grant_id 0.
- Accept to byte_ready: 1 cycle; byte_ready to t_byte: 1 cycle.
- tx_done in cycle n -> IDLE in n+1; next accept earliest in n+1 (zero idle gap).
- Throughput: one byte per frame time + 3 cycles.
- rst asserted in any state returns to IDLE next edge; strobes drop immediately; no partial byte_ready/t_byte pair is emitted after reset.
- tx_done in the same cycle as t_byte is not possible from the transmitter and need not be handled.

## Configuration
- UART_ARB_LOCK_EN defined: on tx_done, if req_lock[grant_id] was high at accept time, rr_ptr is set to grant_id (not grant_id+1), so the same requester wins again if still valid; enables atomic multi-byte messages. Lock bit captured at accept into a 1-bit register.
- Not defined: req_lock ignored, no lock register; strict round-robin.

## Structure
- Shared package uart_pkg: state enum type (IDLE, LOAD, START, WAIT), default DATA_W constant.
- One sub-module rr_picker: combinational round-robin select (inputs valid vector and rr_ptr; outputs found flag and winner index), reused by other arbiters in the design.

## Test plan
- Single requester: req_valid=0001, data 0x55 -> req_ready=0001 one cycle, byte_ready next cycle, t_byte after that, tx_data=0x55 until tx_done.
- All four valid, data 0xA0..0xA3 -> grant order 0,1,2,3,0 with tx_data following; each next grant exactly 1 cycle after tx_done.
- rr_ptr wrap: last grant 3, requesters 1 and 3 valid -> requester 1 wins.
- Reset during WAIT with req_valid=1111 -> outputs at reset values next cycle; first grant after release goes to requester 0.
- Spurious tx_done in IDLE and LOAD -> no state change, no extra strobes.
- With UART_ARB_LOCK_EN, req_lock[2]=1 for 3 bytes while all valid -> grants 2,2,2, then 3 after lock drops.
